// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
// Grants one byte at a time, follows the UART busy flag to frame end, then holds an idle gap.
module uart_tx_arbiter #(
  parameter int DATA_LENGTH    = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]               ack,
  input  logic                             tx_busy,
  output logic                             transmit,
  output logic [DATA_LENGTH-1:0]           data_to_transmit,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             arb_busy,
  output logic                             timeout_err,
  output logic [2:0]                       dbg_state
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int MAX_CNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_RR  = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;

  // First set request bit searching upward from rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Handshake: req is a level a requester holds (with its byte) until its one-cycle ack;
  // req is only looked at in IDLE, so later changes wait for the next arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    transmit    = 1'b0;
    ack         = '0;
    timeout_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          data_d  = req_data[pick_idx*DATA_LENGTH +: DATA_LENGTH];
          state_d = S_START;
        end
      end

      S_START: begin
        transmit      = 1'b1;
        ack[grant_q]  = 1'b1;
        rr_ptr_d      = (grant_q == LAST_RR) ? '0 : grant_q + 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // The byte is lost; its ack has already been given.
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
    end
  end

  assign arb_busy         = (state_q != S_IDLE);
  assign data_to_transmit = data_q;
  assign grant_id         = grant_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, gap, timeout and async reset.
module tb_uart_tx_arbiter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req, ack;
  logic [31:0] req_data;
  logic        tx_busy, transmit, arb_busy, tmo;
  logic [7:0]  dtx;
  logic [1:0]  gid;
  logic [2:0]  dbg;

  logic [3:0]  req_z, ack_z;
  logic [31:0] req_data_z;
  logic        tx_busy_z, transmit_z, arb_busy_z, tmo_z;
  logic [7:0]  dtx_z;
  logic [1:0]  gid_z;
  logic [2:0]  dbg_z;

  uart_tx_arbiter u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_busy(tx_busy), .transmit(transmit), .data_to_transmit(dtx),
    .grant_id(gid), .arb_busy(arb_busy), .timeout_err(tmo), .dbg_state(dbg)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .reset(reset), .req(req_z), .req_data(req_data_z), .ack(ack_z),
    .tx_busy(tx_busy_z), .transmit(transmit_z), .data_to_transmit(dtx_z),
    .grant_id(gid_z), .arb_busy(arb_busy_z), .timeout_err(tmo_z), .dbg_state(dbg_z)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  int n_tx = 0;
  int n_tx_z = 0;
  int n_ack_bad = 0;
  logic [7:0] exp_q[$];
  int exp_g[5] = '{0, 1, 2, 3, 0};

  always @(negedge clk) begin
    if (transmit) n_tx++;
    if (transmit_z) n_tx_z++;
    if (((ack != 4'b0) !== transmit) || ($countones(ack) > 1)) n_ack_bad++;
    if (((ack_z != 4'b0) !== transmit_z) || ($countones(ack_z) > 1)) n_ack_bad++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_tx(input int max_c);
    int n;
    n = 0;
    step();
    while (!transmit && n < max_c) begin
      step();
      n++;
    end
    check_eq("tx_seen", {31'b0, transmit}, 32'd1);
  endtask

  // Called in the strobe cycle; UART rises after dly cycles, stays busy len cycles.
  task automatic run_frame(input int dly, input int len, input int exp_gap);
    int n;
    step();
    check_eq("strobe_one_cycle", {27'b0, transmit, ack}, 32'd0);
    repeat (dly - 1) step();
    tx_busy = 1'b1;
    repeat (len) step();
    tx_busy = 1'b0;
    n = 0;
    step();
    while (arb_busy && n < 300) begin
      n++;
      step();
    end
    check_eq("gap_len", n, exp_gap);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req = '0; req_data = '0; tx_busy = 1'b0;
    req_z = '0; req_data_z = '0; tx_busy_z = 1'b0;
    repeat (3) step();
    check_eq("rst_strobes", {26'b0, transmit, ack, tmo}, 32'd0);
    check_eq("rst_arb_busy", {31'b0, arb_busy}, 32'd0);
    check_eq("rst_data", {24'b0, dtx}, 32'd0);
    check_eq("rst_grant", {30'b0, gid}, 32'd0);
    check_eq("rst_state", {29'b0, dbg}, 32'd0);
    reset = 1'b1;
    step();

    // 1) single requester 2
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    step();
    check_eq("t1_transmit", {31'b0, transmit}, 32'd1);
    check_eq("t1_ack", {28'b0, ack}, 32'b0100);
    check_eq("t1_grant", {30'b0, gid}, 32'd2);
    check_eq("t1_data", {24'b0, dtx}, 32'hA5);
    check_eq("t1_arb_busy", {31'b0, arb_busy}, 32'd1);
    req = 4'b0000;
    run_frame(2, 100, 16);
    check_eq("t1_tx_count", n_tx, 32'd1);
    check_eq("t1_data_held", {24'b0, dtx}, 32'hA5);
    check_eq("t1_idle", {29'b0, dbg}, 32'd0);

    // 2) all four held from rr_ptr=0
    do_reset();
    req_data = 32'h1312_1110;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(exp_g[i]));
    for (int i = 0; i < 5; i++) begin
      wait_tx(10);
      check_eq("t2_data", {24'b0, dtx}, {24'b0, exp_q.pop_front()});
      check_eq("t2_grant", {30'b0, gid}, exp_g[i]);
      check_eq("t2_ack", {28'b0, ack}, 32'd1 << exp_g[i]);
      if (i == 4) req = 4'b1000;
      run_frame(2, 5, 16);
    end

    // 3) wrap-around
    wait_tx(10);
    check_eq("t3_grant3", {30'b0, gid}, 32'd3);
    check_eq("t3_data3", {24'b0, dtx}, 32'h13);
    req = 4'b1001;
    run_frame(2, 5, 16);
    wait_tx(10);
    check_eq("t3_wrap_grant0", {30'b0, gid}, 32'd0);
    run_frame(2, 5, 16);
    wait_tx(10);
    check_eq("t3_then_grant3", {30'b0, gid}, 32'd3);
    req = 4'b0000;
    run_frame(2, 5, 16);

    // 4) UART never goes busy
    req_data = 32'h1312_5C10;
    req = 4'b0010;
    wait_tx(10);
    check_eq("t4_grant", {30'b0, gid}, 32'd1);
    check_eq("t4_ack", {28'b0, ack}, 32'b0010);
    n = 0;
    while (!tmo && n < 200) begin
      step();
      n++;
    end
    check_eq("t4_timeout_at", n, 32'd64);
    check_eq("t4_arb_busy_at_timeout", {31'b0, arb_busy}, 32'd1);
    step();
    check_eq("t4_idle_after", {30'b0, arb_busy, tmo}, 32'd0);
    step();
    check_eq("t4_regrant_tx", {31'b0, transmit}, 32'd1);
    check_eq("t4_regrant_id", {30'b0, gid}, 32'd1);

    // 5) async reset in WAIT_DONE
    req = 4'b0000;
    tx_busy = 1'b1;
    step();
    step();
    check_eq("t5_in_wait_done", {29'b0, dbg}, 32'd3);
    check_eq("t5_data_before", {24'b0, dtx}, 32'h5C);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_async_strobes", {25'b0, transmit, ack, tmo, arb_busy}, 32'd0);
    check_eq("t5_async_data", {24'b0, dtx}, 32'd0);
    check_eq("t5_async_grant", {30'b0, gid}, 32'd0);
    tx_busy = 1'b0;
    step();
    step();
    reset = 1'b1;
    req = 4'b0010;
    step();
    check_eq("t5_latency_tx", {31'b0, transmit}, 32'd1);
    check_eq("t5_grant", {30'b0, gid}, 32'd1);
    req = 4'b0000;

    // 6) zero gap, back-to-back frames
    req_data_z = 32'h0000_003C;
    req_z = 4'b0001;
    n = 0;
    step();
    while (!transmit_z && n < 20) begin
      step();
      n++;
    end
    check_eq("t6_first_tx", {31'b0, transmit_z}, 32'd1);
    for (int f = 0; f < 3; f++) begin
      check_eq("t6_data", {24'b0, dtx_z}, 32'h3C);
      check_eq("t6_ack", {28'b0, ack_z}, 32'b0001);
      step();
      step();
      tx_busy_z = 1'b1;
      repeat (10) step();
      tx_busy_z = 1'b0;
      n = 0;
      while (n < 50) begin
        step();
        n++;
        if (transmit_z) break;
      end
      check_eq("t6_b2b_spacing", n, 32'd2);
    end
    req_z = 4'b0000;
    step();
    check_eq("t6_tx_count", n_tx_z, 32'd4);

    check_eq("ack_strobe_rules", n_ack_bad, 32'd0);

    // report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
